freq_report_uart_tx: RTL and testbench

- Serial transmitter toward the MCU on the f_to_mcu line. It is the transmit side of the MCU link whose receive side is mcu_to_f.
- Accepts one 32-bit frequency-counter result plus a channel tag. It serializes them as a fixed 7-byte UART frame: 8N1, LSB-first.
- Sits in the top level between the frequency counters (clk_200 domain) and the f_to_mcu pin.

---
 rtl/freq_report_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_freq_report_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_report_uart_tx.sv
// freq_report_uart_tx
// Serialises one {channel, 32-bit frequency} result into a fixed 7-byte UART
// frame on the f_to_mcu line: SYNC, CHAN, FREQ[31:24..7:0], XOR checksum.
// Each byte is start(0), 8 data bits LSB first, then STOP_BITS stop bits(1).
//
// Build option: define FREQ_TX_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit(s) of every byte.
module freq_report_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 1736,
  parameter int unsigned STOP_BITS    = 1,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_chan,
  input  logic [31:0] in_freq,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef FREQ_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  // Baud counter reloads with CLKS_PER_BIT-1 and advances the bit on zero.
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_STOP   = 3'(STOP_BITS - 1);
  localparam logic [2:0]  LAST_DATA   = 3'd7;
  localparam logic [2:0]  LAST_BYTE   = 3'd6;

  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_idx;
  logic [39:0] hold;        // {5'b0, chan, freq} captured at accept

  logic [7:0]  cur_byte;
  logic [2:0]  bit_nxt;
  logic        baud_wrap;
  logic        accept;

  // Byte idx of the frame built from the holding register.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [39:0] word);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = word[39:32];
      3'd2:    b = word[31:24];
      3'd3:    b = word[23:16];
      3'd4:    b = word[15:8];
      3'd5:    b = word[7:0];
      default: b = word[39:32] ^ word[31:24] ^ word[23:16]
                   ^ word[15:8] ^ word[7:0];
    endcase
    return b;
  endfunction

`ifdef FREQ_TX_PARITY_EN
  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  // Current byte, next data-bit index and bit-boundary strobe.
  always_comb begin
    cur_byte  = frame_byte(byte_idx, hold);
    bit_nxt   = bit_cnt + 3'd1;
    baud_wrap = (baud_cnt == 16'd0);
    accept    = in_valid && in_ready;
  end

  // Frame sequencer: tx is registered so it changes exactly on bit boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      baud_cnt   <= 16'd0;
      bit_cnt    <= 3'd0;
      byte_idx   <= 3'd0;
      hold       <= 40'd0;
      tx         <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            hold     <= {5'b0, in_chan, in_freq};
            state    <= ST_START;
            tx       <= 1'b0;
            baud_cnt <= BAUD_RELOAD;
            bit_cnt  <= 3'd0;
            byte_idx <= 3'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        ST_START: begin
          if (!baud_wrap) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            baud_cnt <= BAUD_RELOAD;
            bit_cnt  <= 3'd0;
            tx       <= cur_byte[0];
            state    <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (!baud_wrap) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= 3'd0;
`ifdef FREQ_TX_PARITY_EN
              tx      <= even_parity(cur_byte);
              state   <= ST_PARITY;
`else
              tx      <= 1'b1;
              state   <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_nxt;
              tx      <= cur_byte[bit_nxt];
            end
          end
        end

`ifdef FREQ_TX_PARITY_EN
        ST_PARITY: begin
          if (!baud_wrap) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            baud_cnt <= BAUD_RELOAD;
            bit_cnt  <= 3'd0;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (!baud_wrap) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt != LAST_STOP) begin
              bit_cnt <= bit_nxt;
            end else if (byte_idx == LAST_BYTE) begin
              // Frame complete: ready for the next word in this very cycle.
              bit_cnt    <= 3'd0;
              byte_idx   <= 3'd0;
              baud_cnt   <= 16'd0;
              tx         <= 1'b1;
              state      <= ST_IDLE;
              in_ready   <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              // Next byte starts immediately, no idle gap.
              bit_cnt  <= 3'd0;
              byte_idx <= byte_idx + 3'd1;
              tx       <= 1'b0;
              state    <= ST_START;
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          baud_cnt <= 16'd0;
          bit_cnt  <= 3'd0;
          byte_idx <= 3'd0;
          tx       <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_report_uart_tx.sv
// Directed bench for freq_report_uart_tx: one instance at CLKS_PER_BIT=4,
// STOP_BITS=1 and one at CLKS_PER_BIT=5, STOP_BITS=2, with a UART decoder.
module tb_freq_report_uart_tx;

`ifdef FREQ_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LEN1 = 7 * (10 + PAR) * 4;
  localparam int LEN2 = 7 * (11 + PAR) * 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, tx, busy, frame_done;
  logic [2:0]  in_chan;
  logic [31:0] in_freq;
  logic        v2, rdy2, tx2, busy2, fd2;
  logic [2:0]  chan2;
  logic [31:0] freq2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  freq_report_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .in_freq(in_freq), .tx(tx), .busy(busy),
    .frame_done(frame_done)
  );

  freq_report_uart_tx #(.CLKS_PER_BIT(5), .STOP_BITS(2), .SYNC_BYTE(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2),
    .in_chan(chan2), .in_freq(freq2), .tx(tx2), .busy(busy2),
    .frame_done(fd2)
  );

  function automatic logic txv(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  function automatic logic fdv(input bit sel);
    return sel ? fd2 : frame_done;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the start bit, samples every bit mid-cell and returns
  // the seven bytes, parity bits, frame length (tx fall -> frame_done) and the
  // number of negedges spent waiting for the start bit. Called at a negedge.
  task automatic rx_frame(input bit sel, input int cpb, input int sb,
                          output logic [55:0] bytes, output logic [6:0] par,
                          output int len, output int lead, output int bad);
    logic [7:0] bb [7];
    int nb, total, guard;
    nb    = 10 + sb - 1 + PAR;
    total = 7 * nb * cpb;
    bad   = 0;
    len   = -1;
    par   = '0;
    for (int i = 0; i < 7; i++) bb[i] = 8'h00;
    guard = 0;
    while (txv(sel) !== 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    lead = guard;
    if (guard >= 2000) bad++;
    for (int idx = 0; idx <= total + 10; idx++) begin
      if (idx > 0) @(negedge clk);
      if (fdv(sel) === 1'b1 && len < 0) len = idx;
      if (idx >= total && len >= 0) break;
      if (idx < total && (idx % cpb) == cpb / 2) begin
        int bp, by, j;
        bp = idx / cpb;
        by = bp / nb;
        j  = bp % nb;
        if (j == 0) begin
          if (txv(sel) !== 1'b0) bad++;
        end else if (j <= 8) begin
          bb[by][j-1] = txv(sel);
        end else if (PAR == 1 && j == 9) begin
          par[by] = txv(sel);
        end else begin
          if (txv(sel) !== 1'b1) bad++;
        end
      end
    end
    bytes = {bb[0], bb[1], bb[2], bb[3], bb[4], bb[5], bb[6]};
  endtask

  logic [55:0] bytes_a, bytes_b;
  logic [6:0]  par_a, par_b;
  int          len_a, lead_a, bad_a, len_b, lead_b, bad_b;
  int          lows, fds;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_chan = '0; in_freq = '0;
    v2 = 1'b0; chan2 = '0; freq2 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx", tx, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_tx2", tx2, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // Basic frame chan=3, freq=0BEBC200
    in_valid = 1'b1; in_chan = 3'd3; in_freq = 32'h0BEBC200;
    @(negedge clk);
    in_valid = 1'b0;
    check("acc_tx_low", tx, 1'b0);
    check("acc_in_ready", in_ready, 1'b0);
    check("acc_busy", busy, 1'b1);
    rx_frame(1'b0, 4, 1, bytes_a, par_a, len_a, lead_a, bad_a);
    check("a_bytes", bytes_a, 56'hA5_03_0B_EB_C2_00_21);
    check("a_len", len_a, LEN1);
    check("a_framing", bad_a, 0);
    check("a_done_ready", in_ready, 1'b1);
    check("a_done_busy", busy, 1'b0);
    repeat (3) @(negedge clk);

    // Back-to-back with in_valid held high; second word applied after first accept
    in_valid = 1'b1; in_chan = 3'd1; in_freq = 32'h12345678;
    @(negedge clk);
    in_chan = 3'd6; in_freq = 32'hDEADBEEF;
    rx_frame(1'b0, 4, 1, bytes_a, par_a, len_a, lead_a, bad_a);
    rx_frame(1'b0, 4, 1, bytes_b, par_b, len_b, lead_b, bad_b);
    in_valid = 1'b0;
    check("b2b_w1_bytes", bytes_a, 56'hA5_01_12_34_56_78_09);
    check("b2b_w1_len", len_a, LEN1);
    check("b2b_w2_lead", lead_b, 1);
    check("b2b_w2_bytes", bytes_b, 56'hA5_06_DE_AD_BE_EF_24);
    check("b2b_w2_len", len_b, LEN1);
    check("b2b_framing", bad_a + bad_b, 0);
    repeat (3) @(negedge clk);

    // in_valid pulse and in_freq change mid-frame are ignored
    in_valid = 1'b1; in_chan = 3'd5; in_freq = 32'h00FF00FF;
    @(negedge clk);
    in_valid = 1'b0;
    fork
      rx_frame(1'b0, 4, 1, bytes_a, par_a, len_a, lead_a, bad_a);
      begin
        repeat (50) @(negedge clk);
        in_valid = 1'b1; in_chan = 3'd2; in_freq = 32'hFFFFFFFF;
        @(negedge clk);
        in_valid = 1'b0;
      end
    join
    check("mid_bytes", bytes_a, 56'hA5_05_00_FF_00_FF_05);
    check("mid_len", len_a, LEN1);
    check("mid_framing", bad_a, 0);
    repeat (3) @(negedge clk);

    // Reset at cycle 100 of a frame
    in_valid = 1'b1; in_chan = 3'd4; in_freq = 32'h0000FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_tx", tx, 1'b1);
    check("mrst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_in_ready", in_ready, 1'b1);
    lows = 0; fds = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) lows++;
      if (frame_done !== 1'b0) fds++;
      @(negedge clk);
    end
    check("mrst_no_low_bits", lows, 0);
    check("mrst_no_done", fds, 0);
    in_valid = 1'b1; in_chan = 3'd7; in_freq = 32'h80000001;
    @(negedge clk);
    in_valid = 1'b0;
    rx_frame(1'b0, 4, 1, bytes_a, par_a, len_a, lead_a, bad_a);
    check("post_rst_bytes", bytes_a, 56'hA5_07_80_00_00_01_86);
    check("post_rst_framing", bad_a, 0);
    repeat (3) @(negedge clk);

    // Reset together with in_valid: nothing accepted
    reset = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check("rv_busy", busy, 1'b0);
    check("rv_tx", tx, 1'b1);
    repeat (20) @(negedge clk);
    check("rv_still_idle", busy, 1'b0);

    // Parity vector frame chan=0, freq=1
    in_valid = 1'b1; in_chan = 3'd0; in_freq = 32'h00000001;
    @(negedge clk);
    in_valid = 1'b0;
    rx_frame(1'b0, 4, 1, bytes_a, par_a, len_a, lead_a, bad_a);
    check("p_bytes", bytes_a, 56'hA5_00_00_00_00_01_01);
    check("p_len", len_a, LEN1);
`ifdef FREQ_TX_PARITY_EN
    check("p_parity", par_a, 7'b1100000);
`endif
    check("p_framing", bad_a, 0);
    repeat (3) @(negedge clk);

    // Two stop bits, CLKS_PER_BIT=5
    v2 = 1'b1; chan2 = 3'd2; freq2 = 32'hA5A55A5A;
    @(negedge clk);
    v2 = 1'b0;
    check("sb2_tx_low", tx2, 1'b0);
    rx_frame(1'b1, 5, 2, bytes_b, par_b, len_b, lead_b, bad_b);
    check("sb2_bytes", bytes_b, 56'hA5_02_A5_A5_5A_5A_02);
    check("sb2_len", len_b, LEN2);
    check("sb2_framing", bad_b, 0);
    check("sb2_ready", rdy2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
